axis_ipv4_rx_check: RTL and testbench

Inline AXI-Stream IPv4 receive checker on the consume side of `axis_loop`, between its 32-bit master stream and the packet sink. Each packet passes through a one-beat register/skid stage. On the fly, the block checks the IPv4 header (version, IHL, header checksum) and compares the total-length field against the actual byte count. The verdict is flagged on the packet's `tlast` output beat, and running status counters are kept.

---
 rtl/axis_ipv4_rx_check_if.sv | 16 +
 rtl/axis_ipv4_rx_check.sv | 205 ++++++++++++++++++++
 tb/tb_axis_ipv4_rx_check.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_ipv4_rx_check_if.sv
// AXI-Stream beat bundle (32-bit data, byte strobes, last, user flag) for the IPv4 rx checker.
// No storage: wires only, zero latency.
// Backpressure is the plain tvalid/tready handshake; the master holds the beat until tready.
interface axis_ipv4_rx_check_if;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        tuser;

  modport master (output tdata, output tstrb, output tlast, output tvalid, output tuser,
                  input tready);
  modport slave  (input tdata, input tstrb, input tlast, input tvalid,
                  output tready);
endinterface

// File: rtl/axis_ipv4_rx_check.sv
// Inline IPv4 receive checker: passes beats through unchanged, flags header/length/strobe errors on tlast.
// Latency 1 cycle (output register), plus one skid slot that absorbs a stalled output beat.
// s_axis.tready is registered and drops only once the skid slot holds a beat; packets are never dropped.
module axis_ipv4_rx_check #(
  parameter int CNT_W = 32
) (
  input  logic                  aclk_0,
  input  logic                  aresetn_0,
  axis_ipv4_rx_check_if.slave   s_axis,
  axis_ipv4_rx_check_if.master  m_axis,
  output logic [CNT_W-1:0]      pkt_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [5:0]            last_err
);

  typedef enum logic {ST_HDR, ST_PAY} state_t;

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  strb;
    logic        last;
    logic        user;
  } beat_t;

  // checker state
  state_t      state_q;
  logic [3:0]  widx_q;
  logic [3:0]  ver_q;
  logic [3:0]  ihl_q;
  logic [15:0] tlen_q;
  logic [19:0] acc_q;
  logic [15:0] bcnt_q;
  logic        strb_err_q;
  logic        cks_err_q;

  // pipeline state
  beat_t       out_q;
  logic        out_vld_q;
  beat_t       skid_q;
  logic        skid_vld_q;
  logic        skid_vld_d;
  logic        s_rdy_q;
  logic        out_free;

  // status counters
  logic [CNT_W-1:0] pkt_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [5:0]       last_err_q;

  // per-beat view of the packet including the beat being accepted now
  logic        in_fire;
  logic        in_hdr;
  logic        word0;
  logic [3:0]  ver_cur;
  logic [3:0]  ihl_cur;
  logic [15:0] tlen_cur;
  logic        ihl_ok;
  logic        hdr_last;
  logic [19:0] acc_sum;
  logic [19:0] fold1;
  logic [15:0] fold2;
  logic        cks_bad;
  logic [2:0]  pop;
  logic [16:0] bcnt_sum;
  logic [15:0] bcnt_new;
  logic        strb_bad;
  logic        strb_err_cur;
  logic [5:0]  code_cur;
  beat_t       in_beat;

  assign in_fire  = s_axis.tvalid & s_rdy_q;
  assign in_hdr   = (state_q == ST_HDR);
  assign word0    = in_hdr && (widx_q == 4'd0);
  assign ver_cur  = word0 ? s_axis.tdata[31:28] : ver_q;
  assign ihl_cur  = word0 ? s_axis.tdata[27:24] : ihl_q;
  assign tlen_cur = word0 ? s_axis.tdata[15:0]  : tlen_q;
  assign ihl_ok   = (ihl_cur >= 4'd5);
  assign hdr_last = in_hdr && ihl_ok && (widx_q == (ihl_cur - 4'd1));

  // ones-complement header sum: 20-bit running add, then two end-around folds
  assign acc_sum = (word0 ? 20'd0 : acc_q)
                 + {4'd0, s_axis.tdata[31:16]} + {4'd0, s_axis.tdata[15:0]};
  assign fold1   = {4'd0, acc_sum[15:0]} + {16'd0, acc_sum[19:16]};
  assign fold2   = fold1[15:0] + {12'd0, fold1[19:16]};
  assign cks_bad = (fold2 != 16'hFFFF);

  // byte count: full word on body beats, strobe popcount on the last beat, saturating
  assign pop      = {2'd0, s_axis.tstrb[0]} + {2'd0, s_axis.tstrb[1]}
                  + {2'd0, s_axis.tstrb[2]} + {2'd0, s_axis.tstrb[3]};
  assign bcnt_sum = {1'b0, (word0 ? 16'd0 : bcnt_q)}
                  + (s_axis.tlast ? {14'd0, pop} : 17'd4);
  assign bcnt_new = bcnt_sum[16] ? 16'hFFFF : bcnt_sum[15:0];

  // only left-justified contiguous strobes are legal on the last beat
  assign strb_bad = s_axis.tlast ?
                    !((s_axis.tstrb == 4'h8) || (s_axis.tstrb == 4'hC) ||
                      (s_axis.tstrb == 4'hE) || (s_axis.tstrb == 4'hF)) :
                    (s_axis.tstrb != 4'hF);
  assign strb_err_cur = (word0 ? 1'b0 : strb_err_q) | strb_bad;

  // checksum and length are meaningless for a truncated header, so they are masked there
  assign code_cur = {strb_err_cur,
                     in_hdr,
                     !in_hdr && (bcnt_new != tlen_cur),
                     !in_hdr && cks_err_q,
                     !ihl_ok,
                     (ver_cur != 4'd4)};

  assign in_beat.dat  = s_axis.tdata;
  assign in_beat.strb = s_axis.tstrb;
  assign in_beat.last = s_axis.tlast;
  assign in_beat.user = s_axis.tlast & (|code_cur);

  // Header/payload FSM and per-packet check state, advanced only on accepted input beats
  always_ff @(posedge aclk_0 or negedge aresetn_0) begin
    if (!aresetn_0) begin
      state_q    <= ST_HDR;
      widx_q     <= 4'd0;
      ver_q      <= 4'd0;
      ihl_q      <= 4'd0;
      tlen_q     <= 16'd0;
      acc_q      <= 20'd0;
      bcnt_q     <= 16'd0;
      strb_err_q <= 1'b0;
      cks_err_q  <= 1'b0;
    end else if (in_fire) begin
      ver_q      <= ver_cur;
      ihl_q      <= ihl_cur;
      tlen_q     <= tlen_cur;
      bcnt_q     <= bcnt_new;
      strb_err_q <= strb_err_cur;
      if (in_hdr) acc_q <= acc_sum;
      if (word0) cks_err_q <= 1'b0;
      if (hdr_last) cks_err_q <= cks_bad;
      if (s_axis.tlast) begin
        state_q <= ST_HDR;
        widx_q  <= 4'd0;
      end else if (in_hdr) begin
        if (!ihl_ok || hdr_last) begin
          state_q <= ST_PAY;
          widx_q  <= 4'd0;
        end else begin
          widx_q <= widx_q + 4'd1;
        end
      end
    end
  end

  // Status counters update on the edge that accepts the input tlast beat
  always_ff @(posedge aclk_0 or negedge aresetn_0) begin
    if (!aresetn_0) begin
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      last_err_q <= 6'd0;
    end else if (in_fire && s_axis.tlast) begin
      pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      if (|code_cur) begin
        err_cnt_q  <= err_cnt_q + CNT_W'(1);
        last_err_q <= code_cur;
      end
    end
  end

  // The output slot is free when empty or being consumed this cycle; the skid fills only when it is not
  assign out_free   = !out_vld_q || m_axis.tready;
  assign skid_vld_d = out_free ? 1'b0 : (skid_vld_q | in_fire);

  // Output register + skid slot; input ready is registered from the next skid occupancy
  always_ff @(posedge aclk_0 or negedge aresetn_0) begin
    if (!aresetn_0) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      s_rdy_q    <= 1'b0;
    end else begin
      skid_vld_q <= skid_vld_d;
      s_rdy_q    <= !skid_vld_d;
      if (out_free) begin
        if (skid_vld_q) begin
          out_q     <= skid_q;
          out_vld_q <= 1'b1;
        end else if (in_fire) begin
          out_q     <= in_beat;
          out_vld_q <= 1'b1;
        end else begin
          out_vld_q <= 1'b0;
        end
      end else if (in_fire) begin
        skid_q <= in_beat;
      end
    end
  end

  assign s_axis.tready = s_rdy_q;
  assign m_axis.tdata  = out_q.dat;
  assign m_axis.tstrb  = out_q.strb;
  assign m_axis.tlast  = out_q.last;
  assign m_axis.tuser  = out_q.user;
  assign m_axis.tvalid = out_vld_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign last_err      = last_err_q;

endmodule

// File: tb/tb_axis_ipv4_rx_check.sv
// Randomised + directed bench for axis_ipv4_rx_check with a scoreboard and an IPv4 reference model.
// Beats are expected on the output in input order; a monitor compares them as they leave the DUT.
// Output backpressure is driven in several patterns (always ready, 1-0-0-1, random).
module tb_axis_ipv4_rx_check;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
    logic        u;
  } beat_t;

  logic aclk_0 = 1'b0;
  logic aresetn_0 = 1'b0;
  always #5 aclk_0 = ~aclk_0;

  axis_ipv4_rx_check_if s_if ();
  axis_ipv4_rx_check_if m_if ();
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [5:0]       last_err;

  axis_ipv4_rx_check #(.CNT_W(CNT_W)) dut (
    .aclk_0    (aclk_0),
    .aresetn_0 (aresetn_0),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt),
    .last_err  (last_err)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  beat_t       sb_q[$];
  logic [31:0] pw[$];
  logic [3:0]  ps[$];
  int          exp_pkt = 0;
  int          exp_err = 0;
  logic [5:0]  exp_last = 6'd0;
  int          tready_mode = 0;
  bit          gaps_en = 0;
  logic        prev_stall = 1'b0;
  logic [37:0] prev_vec = '0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Expected error code of the packet in pw/ps, computed from the IPv4 rules directly
  function automatic logic [5:0] model_code();
    int          n;
    logic [31:0] w0;
    logic [31:0] w;
    int          ihl;
    int          sum;
    int          bytes;
    bit          trunc;
    bit          cks_bad;
    bit          len_bad;
    bit          sbad;
    n = pw.size();
    w0 = pw[0];
    ihl = int'(w0[27:24]);
    trunc = (ihl >= 5) ? (n <= ihl) : (n == 1);
    cks_bad = 0;
    if (ihl >= 5 && !trunc) begin
      sum = 0;
      for (int i = 0; i < ihl; i++) begin
        w = pw[i];
        sum += int'(w[31:16]) + int'(w[15:0]);
      end
      while (sum > 65535) sum = (sum % 65536) + (sum / 65536);
      cks_bad = (sum != 65535);
    end
    bytes = 4 * (n - 1) + $countones(ps[n-1]);
    if (bytes > 65535) bytes = 65535;
    len_bad = (bytes != int'(w0[15:0]));
    sbad = !(ps[n-1] inside {4'h8, 4'hC, 4'hE, 4'hF});
    for (int i = 0; i < n - 1; i++) if (ps[i] != 4'hF) sbad = 1;
    return {sbad, trunc, len_bad && !trunc, cks_bad && !trunc, ihl < 5, w0[31:28] != 4'd4};
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    bit acc;
    acc = 0;
    s_if.tdata  = d;
    s_if.tstrb  = s;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    for (int c = 0; c < 2000 && !acc; c++) begin
      @(negedge aclk_0);
      if (s_if.tready) acc = 1;
      @(posedge aclk_0);
      #1;
    end
    s_if.tvalid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL s_tready_timeout: got no acceptance in 2000 cycles, expected acceptance");
    end
  endtask

  task automatic send_pkt();
    logic [5:0] code;
    beat_t      b;
    int         n;
    code = model_code();
    n = pw.size();
    exp_pkt++;
    if (code != 6'd0) begin
      exp_err++;
      exp_last = code;
    end
    for (int i = 0; i < n; i++) begin
      if (gaps_en && i > 0) repeat ($urandom_range(0, 2)) begin @(posedge aclk_0); #1; end
      b.d = pw[i];
      b.s = ps[i];
      b.l = (i == n - 1);
      b.u = b.l && (code != 6'd0);
      sb_q.push_back(b);
      send_beat(b.d, b.s, b.l);
    end
    check("pkt_cnt", pkt_cnt, exp_pkt);
    check("err_cnt", err_cnt, exp_err);
    check("last_err", last_err, exp_last);
  endtask

  task automatic load_case1(input logic [31:0] w0, input logic [31:0] w2, input logic [3:0] ls);
    pw = '{w0, 32'h0000_0000, w2, 32'hC0A8_0001, 32'hC0A8_0002, 32'h1122_3344, 32'h5566_7788};
    ps = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, ls};
  endtask

  task automatic make_pkt(input int kind);
    logic [31:0] hdr[16];
    logic [31:0] w;
    logic [3:0]  ihl;
    int          npay;
    int          n;
    int          s;
    int          m;
    pw.delete();
    ps.delete();
    ihl = 4'($urandom_range(5, 7));
    npay = $urandom_range(0, 5);
    n = int'(ihl) + npay;
    for (int i = 0; i < 16; i++) hdr[i] = $urandom;
    hdr[0] = {4'h4, ihl, 8'h00, 16'(4 * n)};
    hdr[2][15:0] = 16'h0000;
    s = 0;
    for (int i = 0; i < int'(ihl); i++) s += int'(hdr[i][31:16]) + int'(hdr[i][15:0]);
    while (s > 65535) s = (s % 65536) + (s / 65536);
    hdr[2][15:0] = ~16'(s);
    for (int i = 0; i < int'(ihl); i++) pw.push_back(hdr[i]);
    for (int i = 0; i < npay; i++) pw.push_back($urandom);
    for (int i = 0; i < n; i++) ps.push_back(4'hF);
    w = pw[0];
    case (kind)
      1: pw[2] = pw[2] ^ 32'h0000_0001;
      2: begin w[31:28] = 4'($urandom_range(5, 15)); pw[0] = w; end
      3: case ($urandom_range(0, 2))
           0: ps[n-1] = 4'h8;
           1: ps[n-1] = 4'hC;
           default: ps[n-1] = 4'hE;
         endcase
      4: if ($urandom_range(0, 1) == 1) ps[1] = 4'h7; else ps[n-1] = 4'h3;
      5: begin w[27:24] = 4'($urandom_range(0, 4)); pw[0] = w; end
      6: begin
           m = $urandom_range(1, int'(ihl));
           while (pw.size() > m) begin void'(pw.pop_back()); void'(ps.pop_back()); end
         end
      7: begin w[15:0] = w[15:0] + 16'd4; pw[0] = w; end
      default: ;
    endcase
  endtask

  initial begin
    s_if.tdata  = '0;
    s_if.tstrb  = '0;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b1;

    fork
      // output monitor: stability while stalled, then in-order scoreboard compare
      forever begin
        beat_t e;
        @(negedge aclk_0);
        if (!aresetn_0) begin
          prev_stall = 1'b0;
        end else begin
          if (prev_stall) begin
            check("hold_tvalid", m_if.tvalid, 1);
            check("hold_beat", {m_if.tdata, m_if.tstrb, m_if.tlast, m_if.tuser}, prev_vec);
          end
          if (m_if.tvalid && m_if.tready) begin
            if (sb_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_if.tdata);
            end else begin
              e = sb_q.pop_front();
              check("out_tdata", m_if.tdata, e.d);
              check("out_tstrb", m_if.tstrb, e.s);
              check("out_tlast", m_if.tlast, e.l);
              if (e.l) check("out_tuser", m_if.tuser, e.u);
            end
          end
          prev_stall = m_if.tvalid && !m_if.tready;
          prev_vec = {m_if.tdata, m_if.tstrb, m_if.tlast, m_if.tuser};
        end
      end
      // output backpressure generator
      begin
        logic [3:0] pat;
        int         cyc;
        pat = 4'b1001;
        cyc = 0;
        forever begin
          @(posedge aclk_0);
          #1;
          cyc++;
          case (tready_mode)
            0: m_if.tready = 1'b1;
            1: m_if.tready = pat[cyc % 4];
            default: m_if.tready = ($urandom_range(0, 3) != 0);
          endcase
        end
      end
    join_none

    // reset state
    repeat (3) @(posedge aclk_0);
    @(negedge aclk_0);
    check("rst_s_tready", s_if.tready, 0);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_m_tuser", m_if.tuser, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_last_err", last_err, 0);
    aresetn_0 = 1'b1;
    @(posedge aclk_0);
    #1;
    check("s_tready_after_rst", s_if.tready, 1);

    // good 28-byte packet
    load_case1(32'h4500_001C, 32'h4011_F97D, 4'hF);
    send_pkt();
    check("case1_err_cnt", err_cnt, 0);
    // corrupted checksum
    load_case1(32'h4500_001C, 32'h4011_F97C, 4'hF);
    send_pkt();
    check("case2_last_err", last_err, 6'h04);
    // 26 bytes against total_len 28
    load_case1(32'h4500_001C, 32'h4011_F97D, 4'hC);
    send_pkt();
    check("case3_last_err", last_err, 6'h08);
    // version 6, then two clean packets back to back
    load_case1(32'h6500_001C, 32'h4011_F97D, 4'hF);
    send_pkt();
    check("case4_ver_bit", last_err[0], 1);
    load_case1(32'h4500_001C, 32'h4011_F97D, 4'hF);
    send_pkt();
    load_case1(32'h4500_001C, 32'h4011_F97D, 4'hF);
    send_pkt();

    // 1,0,0,1 output backpressure
    tready_mode = 1;
    for (int k = 0; k < 3; k++) begin
      load_case1(32'h4500_001C, 32'h4011_F97D, 4'hF);
      send_pkt();
    end
    tready_mode = 0;
    repeat (6) @(posedge aclk_0);
    #1;

    // reset in the middle of a packet
    load_case1(32'h4500_001C, 32'h4011_F97D, 4'hF);
    for (int i = 0; i < 3; i++) begin
      beat_t b;
      b.d = pw[i];
      b.s = ps[i];
      b.l = 1'b0;
      b.u = 1'b0;
      sb_q.push_back(b);
      send_beat(b.d, b.s, 1'b0);
    end
    aresetn_0 = 1'b0;
    sb_q.delete();
    exp_pkt = 0;
    exp_err = 0;
    exp_last = 6'd0;
    #1;
    check("mid_rst_s_tready", s_if.tready, 0);
    check("mid_rst_m_tvalid", m_if.tvalid, 0);
    check("mid_rst_m_tdata", m_if.tdata, 0);
    check("mid_rst_pkt_cnt", pkt_cnt, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_last_err", last_err, 0);
    repeat (2) @(posedge aclk_0);
    @(negedge aclk_0);
    aresetn_0 = 1'b1;
    @(posedge aclk_0);
    #1;
    load_case1(32'h4500_001C, 32'h4011_F97D, 4'hF);
    send_pkt();
    check("post_rst_pkt_cnt", pkt_cnt, 1);

    // random packets with random error injection, gaps and random backpressure
    tready_mode = 2;
    gaps_en = 1;
    for (int k = 0; k < 48; k++) begin
      make_pkt(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7));
      send_pkt();
    end
    gaps_en = 0;

    // drain
    for (int c = 0; c < 500 && sb_q.size() != 0; c++) @(posedge aclk_0);
    @(negedge aclk_0);
    check("drain_remaining", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
